// File: rtl/output_port_16x16.sv
// output_port_16x16: round-robin arbiter, FWFT output FIFO and egress handshake for one crossbar port; OUTPUT_PORT_STATS_EN adds counters
module output_port_16x16 #(
  parameter int width   = 8,
  parameter int depth   = 8,
  parameter int timeout = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                port_id,
  input  logic [15:0]               req_valid,
  input  logic [63:0]               req_sel,
  input  logic [16*(width+1)-1:0]   lane_in,
  output logic [15:0]               grant,
  output logic [width-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(depth):0]    count
`ifdef OUTPUT_PORT_STATS_EN
  ,
  output logic [15:0]               pkt_count,
  output logic [7:0]                timeout_count
`endif
);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam int tw = $clog2(timeout + 1);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_t;
  state_t           r_state;
  logic [3:0]       r_last;
  logic [3:0]       r_win;
  logic [15:0]      r_grant;
  logic [tw-1:0]    r_tmo;
  logic [width-1:0] r_mem [depth];
  logic [aw-1:0]    r_wp;
  logic [aw-1:0]    r_rp;
  logic [cw-1:0]    r_cnt;
  logic [15:0]      w_req;
  logic [3:0]       w_next;
  logic [width:0]   w_lane;
  logic             w_take;
  logic             w_push;
  logic             w_pop;
  logic             w_abort;
  // requests aimed at this port, and the first requester after the last winner
  always_comb begin
    w_next = r_last;
    for (int i = 0; i < 16; i++) w_req[i] = req_valid[i] && req_sel[4*i +: 4] == port_id;
    for (int k = 16; k >= 1; k--) if (w_req[r_last + 4'(k)]) w_next = r_last + 4'(k);
  end
  assign w_lane    = lane_in[(width+1)*r_win +: width+1];
  assign w_take    = r_state != IDLE && w_lane[width];
  assign w_push    = w_take && r_cnt != cw'(depth);
  assign w_pop     = out_valid && out_ready;
  assign w_abort   = r_state == WAIT && !w_lane[width] && r_tmo == tw'(timeout - 1);
  assign grant     = r_grant;
  assign out_valid = r_cnt != '0;
  assign out_data  = out_valid ? r_mem[r_rp] : '0;
  assign count     = r_cnt;
  // grant FSM: one grant in flight, released on capture or timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= 4'hf;
      r_win   <= '0;
      r_tmo   <= '0;
    end else if (r_state == IDLE) begin
      if (w_req != '0 && r_cnt < cw'(depth)) begin
        r_grant <= 16'(1) << w_next;
        r_win   <= w_next;
        r_state <= GRANT;
      end
    end else if (w_take || w_abort) begin
      r_grant <= '0;
      r_last  <= r_win;
      r_state <= IDLE;
    end else if (r_state == GRANT) begin
      r_state <= WAIT;
      r_tmo   <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end
  // FIFO storage, written only by a captured lane word
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_lane[width-1:0];
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + cw'(w_push) - cw'(w_pop);
    end
  end
  // a capture into a full FIFO would drop the word; the single in-flight grant rules it out
  always_ff @(posedge clk) begin
    if (!rst) assert (!(w_take && r_cnt == cw'(depth)));
  end
`ifdef OUTPUT_PORT_STATS_EN
  logic [15:0] r_pkt;
  logic [7:0]  r_tocnt;
  // saturating push and abandoned-grant counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt   <= '0;
      r_tocnt <= '0;
    end else begin
      if (w_push && r_pkt != '1) r_pkt <= r_pkt + 1'b1;
      if (w_abort && r_tocnt != '1) r_tocnt <= r_tocnt + 1'b1;
    end
  end
  assign pkt_count     = r_pkt;
  assign timeout_count = r_tocnt;
`endif
endmodule
